nap_alarm_trigger: RTL

- Downstream consumer of the shortcut-setting stage.
- Latches the absolute BCD wake-up target (HH:MM:SS) when the setting stage reports completion, then compares it every cycle against the running real-time clock digits.
- On match, drives the alarm until the user stops it with `#` or the ring timeout expires.
- Sits between the shortcut-setting stage and the buzzer/LED driver; also exports the latched target for the display mux.

---
 rtl/nap_alarm_trigger.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/nap_alarm_trigger.sv
// Alarm trigger: latches a BCD wake-up target, compares it against the running clock and rings.
// Optional snooze (re-arm at current time + SNOOZE_MIN minutes) is built when NAP_SNOOZE_EN is defined.
module nap_alarm_trigger #(
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       completeSetting,
  input  logic       sharp,
  input  logic       snooze,
  input  logic [3:0] hour_ten_in,
  input  logic [3:0] hour_one_in,
  input  logic [3:0] min_ten_in,
  input  logic [3:0] min_one_in,
  input  logic [3:0] sec_ten_in,
  input  logic [3:0] sec_one_in,
  input  logic [3:0] cur_hour_ten,
  input  logic [3:0] cur_hour_one,
  input  logic [3:0] cur_min_ten,
  input  logic [3:0] cur_min_one,
  input  logic [3:0] cur_sec_ten,
  input  logic [3:0] cur_sec_one,
  output logic [3:0] hour_ten_out,
  output logic [3:0] hour_one_out,
  output logic [3:0] min_ten_out,
  output logic [3:0] min_one_out,
  output logic [3:0] sec_ten_out,
  output logic [3:0] sec_one_out,
  output logic       armed,
  output logic       alarm,
  output logic       missed,
  output logic       set_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RING  = 2'd2;
  localparam logic [6:0] RING_LIM = 7'(RING_SECONDS);

  logic [1:0]  state_q, state_d;
  logic [23:0] tgt_q, tgt_d;
  logic [6:0]  ring_q, ring_d;
  logic        missed_q, missed_d;
  logic        set_err_q, set_err_d;
  logic        cs_q;
  logic [3:0]  sec_q;

  logic [23:0] in_tgt, cur_time;
  logic        arm_ev, strobe, tgt_ok, match;

  assign in_tgt   = {hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in};
  assign cur_time = {cur_hour_ten, cur_hour_one, cur_min_ten, cur_min_one, cur_sec_ten, cur_sec_one};
  assign arm_ev   = completeSetting & ~cs_q;
  assign strobe   = (cur_sec_one != sec_q);
  assign match    = (cur_time == tgt_q);

  assign tgt_ok = (hour_ten_in < 4'd2 || (hour_ten_in == 4'd2 && hour_one_in <= 4'd3)) &&
                  hour_one_in <= 4'd9 && min_ten_in <= 4'd5 && min_one_in <= 4'd9 &&
                  sec_ten_in <= 4'd5 && sec_one_in <= 4'd9;

`ifdef NAP_SNOOZE_EN
  localparam logic [4:0] ADD_ONE = 5'(SNOOZE_MIN % 10);
  localparam logic [4:0] ADD_TEN = 5'(SNOOZE_MIN / 10);

  logic [4:0]  m1_sum, m10_sum;
  logic [3:0]  m1, m10, h1, h10;
  logic        m_carry, h_carry;
  logic [23:0] snz_tgt;

  // Digit-wise BCD add of the snooze offset; the running clock is assumed to hold a legal time.
  always_comb begin
    m1_sum  = {1'b0, cur_min_one} + ADD_ONE;
    m_carry = (m1_sum > 5'd9);
    m1      = m_carry ? 4'(m1_sum - 5'd10) : m1_sum[3:0];
    m10_sum = {1'b0, cur_min_ten} + ADD_TEN + {4'd0, m_carry};
    h_carry = (m10_sum > 5'd5);
    m10     = h_carry ? 4'(m10_sum - 5'd6) : m10_sum[3:0];
    h10     = cur_hour_ten;
    h1      = cur_hour_one;
    if (h_carry) begin
      if (cur_hour_ten == 4'd2 && cur_hour_one == 4'd3) begin
        h10 = 4'd0;
        h1  = 4'd0;
      end else if (cur_hour_one == 4'd9) begin
        h10 = cur_hour_ten + 4'd1;
        h1  = 4'd0;
      end else begin
        h1  = cur_hour_one + 4'd1;
      end
    end
    snz_tgt = {h10, h1, m10, m1, cur_sec_ten, cur_sec_one};
  end
`else
  logic [6:0] unused_snz;
  assign unused_snz = {snooze, 6'(SNOOZE_MIN)};
`endif

  // NOTE: every variable gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    ring_d    = ring_q;
    missed_d  = missed_q;
    set_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm_ev) begin
          if (tgt_ok) begin
            tgt_d    = in_tgt;
            missed_d = 1'b0;
            state_d  = S_ARMED;
          end else begin
            set_err_d = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (sharp) begin
          state_d = S_IDLE;
        end else if (arm_ev) begin
          if (tgt_ok) tgt_d = in_tgt;
          else        set_err_d = 1'b1;
        end else if (match) begin
          state_d = S_RING;
          ring_d  = 7'd0;
        end
      end
      S_RING: begin
        if (sharp) begin
          state_d = S_IDLE;
`ifdef NAP_SNOOZE_EN
        end else if (snooze) begin
          tgt_d   = snz_tgt;
          state_d = S_ARMED;
          ring_d  = 7'd0;
`endif
        end else if (strobe) begin
          ring_d = ring_q + 7'd1;
          if (ring_q + 7'd1 == RING_LIM) begin
            state_d  = S_IDLE;
            missed_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= 24'd0;
      ring_q    <= 7'd0;
      missed_q  <= 1'b0;
      set_err_q <= 1'b0;
      cs_q      <= 1'b0;
      sec_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      ring_q    <= ring_d;
      missed_q  <= missed_d;
      set_err_q <= set_err_d;
      cs_q      <= completeSetting;
      sec_q     <= cur_sec_one;
    end
  end

  assign {hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out} = tgt_q;
  assign armed   = (state_q == S_ARMED);
  assign alarm   = (state_q == S_RING);
  assign missed  = missed_q;
  assign set_err = set_err_q;

endmodule
